// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: per-FU result FIFOs drained one entry per cycle, round-robin.
// Broadcast outputs are registered; grant decisions use registered FIFO state only.
module cdb_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned TAG_W     = 6,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BUF_DEPTH = 2,
    localparam int unsigned SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]    req_tag,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_value,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             cdb_valid,
    output logic [TAG_W-1:0]                 cdb_tag,
    output logic [DATA_W-1:0]                cdb_value,
    output logic [SRC_W-1:0]                 cdb_src,
    output logic                             busy
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    logic [TAG_W-1:0]  tag_q   [NUM_REQ][BUF_DEPTH];
    logic [DATA_W-1:0] value_q [NUM_REQ][BUF_DEPTH];
    logic [PTR_W-1:0]  head_q  [NUM_REQ];
    logic [PTR_W-1:0]  head_d  [NUM_REQ];
    logic [PTR_W-1:0]  tail_q  [NUM_REQ];
    logic [PTR_W-1:0]  tail_d  [NUM_REQ];
    logic [CNT_W-1:0]  count_q [NUM_REQ];
    logic [CNT_W-1:0]  count_d [NUM_REQ];
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [SRC_W-1:0]  rr_q;
    logic [SRC_W-1:0]  rr_d;
    logic [SRC_W-1:0]  grant_idx;
    logic              grant_valid;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (count_q[i] < CNT_W'(BUF_DEPTH));
            if (count_q[i] != '0) busy = 1'b1;
        end
    end

    // Scan starting at rr_q; first non-empty FIFO wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            automatic int unsigned idx = (32'(rr_q) + k) % NUM_REQ;
            if (!grant_valid && count_q[idx] != '0) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'(idx);
            end
        end
        rr_d = rr_q;
        if (grant_valid) begin
            rr_d = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            push[i]    = req_valid[i] && req_ready[i];
            pop[i]     = grant_valid && (grant_idx == SRC_W'(i));
            head_d[i]  = pop[i]  ? ptr_inc(head_q[i]) : head_q[i];
            tail_d[i]  = push[i] ? ptr_inc(tail_q[i]) : tail_q[i];
            count_d[i] = count_q[i];
            case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
            rr_q      <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_src   <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                head_q[i]  <= head_d[i];
                tail_q[i]  <= tail_d[i];
                count_q[i] <= count_d[i];
            end
            rr_q      <= rr_d;
            cdb_valid <= grant_valid;
            if (grant_valid) begin
                cdb_tag   <= tag_q[grant_idx][head_q[grant_idx]];
                cdb_value <= value_q[grant_idx][head_q[grant_idx]];
                cdb_src   <= grant_idx;
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                tag_q[i][tail_q[i]]   <= req_tag[i];
                value_q[i][tail_q[i]] <= req_value[i];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued at issue time and
// a negedge monitor pops and compares every cycle the CDB carries a result.
module tb_cdb_arbiter;

    localparam int NR = 4;
    localparam int TW = 8;
    localparam int DW = 32;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    flush;
    logic [NR-1:0]           req_valid;
    logic [NR-1:0][TW-1:0]   req_tag;
    logic [NR-1:0][DW-1:0]   req_value;
    logic [NR-1:0]           req_ready;
    logic                    cdb_valid;
    logic [TW-1:0]           cdb_tag;
    logic [DW-1:0]           cdb_value;
    logic [1:0]              cdb_src;
    logic                    busy;

    cdb_arbiter #(
        .NUM_REQ   (NR),
        .TAG_W     (TW),
        .DATA_W    (DW),
        .BUF_DEPTH (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_value (req_value),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .cdb_src   (cdb_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] value;
        logic [1:0]    src;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] val_of(input logic [TW-1:0] t);
        return 32'hA5A5_0000 | 32'(t);
    endfunction

    task automatic expect_bc(input logic [TW-1:0] t, input logic [DW-1:0] v,
                             input logic [1:0] s);
        sb.push_back('{tag: t, value: v, src: s});
    endtask

    task automatic offer(input int i, input logic [TW-1:0] t);
        req_valid[i] = 1'b1;
        req_tag[i]   = t;
        req_value[i] = val_of(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        req_valid = '0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || cdb_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_idle"}, {62'd0, busy, cdb_valid}, 64'd0);
    endtask

    always @(negedge clk) begin
        if (cdb_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bc: got tag %0h src %0d, expected no broadcast",
                         cdb_tag, cdb_src);
            end else begin
                mon_e = sb.pop_front();
                check("bc_tag", 64'(cdb_tag), 64'(mon_e.tag));
                check("bc_value", 64'(cdb_value), 64'(mon_e.value));
                check("bc_src", 64'(cdb_src), 64'(mon_e.src));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int  n;
        logic acc;
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_tag   = '0;
        req_value = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_valid", 64'(cdb_valid), 64'd0);
        check("rst_tag", 64'(cdb_tag), 64'd0);
        check("rst_value", 64'(cdb_value), 64'd0);
        check("rst_src", 64'(cdb_src), 64'd0);
        check("rst_ready", 64'(req_ready), 64'hF);
        check("rst_busy", 64'(busy), 64'd0);

        // Single push from FU2
        req_valid[2] = 1'b1;
        req_tag[2]   = 8'd5;
        req_value[2] = 32'hDEAD;
        expect_bc(8'd5, 32'hDEAD, 2'd2);
        step();
        check("single_busy_e1", 64'(busy), 64'd1);
        check("single_valid_e1", 64'(cdb_valid), 64'd0);
        step();
        check("single_valid_e2", 64'(cdb_valid), 64'd1);
        step();
        check("single_valid_e3", 64'(cdb_valid), 64'd0);
        check("single_busy_e3", 64'(busy), 64'd0);

        // Return rr_ptr to 0 before contention
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Contention: all four at once, rr_ptr=0
        for (int i = 0; i < NR; i++) begin
            offer(i, 8'(i + 1));
            expect_bc(8'(i + 1), val_of(8'(i + 1)), 2'(i));
        end
        step();
        for (int c = 0; c < 4; c++) begin
            step();
            check("contend_b2b", 64'(cdb_valid), 64'd1);
        end
        step();
        check("contend_end", 64'(cdb_valid), 64'd0);
        // rr_ptr back at 0: FU0 ahead of FU3
        offer(3, 8'h0E);
        offer(0, 8'h0B);
        expect_bc(8'h0B, val_of(8'h0B), 2'd0);
        expect_bc(8'h0E, val_of(8'h0E), 2'd3);
        step();
        wait_idle("rr0");

        // Round-robin wrap: FU2 alone sets rr_ptr=3, then FU1+FU3
        offer(2, 8'h21);
        expect_bc(8'h21, val_of(8'h21), 2'd2);
        step();
        wait_idle("wrap_a");
        offer(1, 8'h31);
        offer(3, 8'h33);
        expect_bc(8'h33, val_of(8'h33), 2'd3);
        expect_bc(8'h31, val_of(8'h31), 2'd1);
        step();
        wait_idle("wrap_b");
        // rr_ptr=2: FU2 must beat FU1
        offer(1, 8'h41);
        offer(2, 8'h42);
        expect_bc(8'h42, val_of(8'h42), 2'd2);
        expect_bc(8'h41, val_of(8'h41), 2'd1);
        step();
        wait_idle("wrap_c");

        // Backpressure on FU1 with rr_ptr=2
        expect_bc(8'h22, val_of(8'h22), 2'd2);
        expect_bc(8'h23, val_of(8'h23), 2'd3);
        expect_bc(8'h20, val_of(8'h20), 2'd0);
        expect_bc(8'h10, val_of(8'h10), 2'd1);
        expect_bc(8'h32, val_of(8'h32), 2'd2);
        expect_bc(8'h33, val_of(8'h33), 2'd3);
        expect_bc(8'h30, val_of(8'h30), 2'd0);
        expect_bc(8'h11, val_of(8'h11), 2'd1);
        expect_bc(8'h12, val_of(8'h12), 2'd1);
        offer(0, 8'h20);
        offer(1, 8'h10);
        offer(2, 8'h22);
        offer(3, 8'h23);
        step();
        offer(0, 8'h30);
        offer(1, 8'h11);
        offer(2, 8'h32);
        offer(3, 8'h33);
        step();
        check("bp_ready1_full", 64'(req_ready[1]), 64'd0);
        offer(1, 8'h12);
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            acc = req_ready[1];
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = '0;
        check("bp_hold_edges", 64'(n), 64'd4);
        wait_idle("bp");

        // Flush with five results buffered (rr_ptr=2)
        for (int i = 0; i < NR; i++) offer(i, 8'(8'h50 + i));
        step();
        expect_bc(8'h52, val_of(8'h52), 2'd2);
        offer(0, 8'h60);
        offer(1, 8'h61);
        step();
        flush = 1'b1;
        offer(0, 8'h6F);
        step();
        flush = 1'b0;
        check("flush_valid", 64'(cdb_valid), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_ready", 64'(req_ready), 64'hF);
        repeat (4) step();
        // rr_ptr cleared: FU1 ahead of FU3
        offer(1, 8'h71);
        offer(3, 8'h73);
        expect_bc(8'h71, val_of(8'h71), 2'd1);
        expect_bc(8'h73, val_of(8'h73), 2'd3);
        step();
        check("postflush_lat1", 64'(cdb_valid), 64'd0);
        step();
        check("postflush_lat2", 64'(cdb_valid), 64'd1);
        wait_idle("flush");

        // Reset mid-stream with FIFOs filling (rr_ptr=0)
        for (int i = 0; i < NR; i++) offer(i, 8'(8'h80 + i));
        step();
        expect_bc(8'h80, val_of(8'h80), 2'd0);
        for (int i = 0; i < NR; i++) offer(i, 8'(8'h90 + i));
        step();
        check("pre_rst_ready", 64'(req_ready), 64'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_valid", 64'(cdb_valid), 64'd0);
        check("mrst_tag", 64'(cdb_tag), 64'd0);
        check("mrst_value", 64'(cdb_value), 64'd0);
        check("mrst_src", 64'(cdb_src), 64'd0);
        check("mrst_ready", 64'(req_ready), 64'hF);
        check("mrst_busy", 64'(busy), 64'd0);
        offer(1, 8'h0A);
        expect_bc(8'h0A, val_of(8'h0A), 2'd1);
        step();
        check("mrst_lat1", 64'(cdb_valid), 64'd0);
        step();
        check("mrst_lat2", 64'(cdb_valid), 64'd1);
        wait_idle("mrst");

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
